// File: rtl/cci_mpf_prim_scoreboard_arb.sv
// cci_mpf_prim_scoreboard_arb
//
// Shares one in-order, output-buffered scoreboard among N_CLIENTS requesters.
// Allocation is round-robin arbitrated, and each entry's meta-data carries the
// owning client ID in its upper bits. In-order scoreboard output is steered
// back to the owning client. A per-client cap limits allocated, undelivered
// entries. A drain handshake lets a controller quiesce the scoreboard.
//
// Build option: CCI_MPF_SCOREBOARD_ARB_OUT_REG_EN
//   undefined - rsp_* driven combinationally from the scoreboard head.
//   defined   - a 2-entry skid buffer registers rsp_*. This adds one cycle of
//               latency but still sustains one response per cycle.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | normal operation; allocations granted round-robin
// DRAIN | drain requested; no grants, deliveries continue until empty
// IDLE  | quiesced; drained_o=1 until drain_req_i drops

module cci_mpf_prim_scoreboard_arb #(
    parameter int N_CLIENTS       = 4,
    parameter int N_ENTRIES       = 32,
    parameter int N_DATA_BITS     = 64,
    parameter int N_META_BITS     = 1,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDX_W = $clog2(N_ENTRIES),
    localparam int CIB   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
    localparam int MW    = N_META_BITS + CIB,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [N_CLIENTS-1:0]             req_en_i,
    input  logic [N_CLIENTS*N_META_BITS-1:0] req_meta_i,
    output logic [N_CLIENTS-1:0]             req_grant_o,
    output logic [IDX_W-1:0]                 grant_idx_o,
    output logic                             sb_enq_en_o,
    output logic [MW-1:0]                    sb_enqMeta_o,
    input  logic                             sb_notFull_i,
    input  logic [IDX_W-1:0]                 sb_enqIdx_i,
    output logic                             sb_deq_en_o,
    input  logic                             sb_notEmpty_i,
    input  logic [N_DATA_BITS-1:0]           sb_first_i,
    input  logic [MW-1:0]                    sb_firstMeta_i,
    output logic [N_CLIENTS-1:0]             rsp_valid_o,
    input  logic [N_CLIENTS-1:0]             rsp_ready_i,
    output logic [N_DATA_BITS-1:0]           rsp_data_o,
    output logic [N_META_BITS-1:0]           rsp_meta_o,
    input  logic                             drain_req_i,
    output logic                             drained_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t               state_q;
    logic                 drained_q;
    logic [CIB-1:0]       rr_ptr_q;
    logic [CIB-1:0]       rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q [N_CLIENTS];
    logic [CNT_W-1:0]     cnt_d [N_CLIENTS];

    logic [N_CLIENTS-1:0] elig;
    logic [N_CLIENTS-1:0] grant;
    logic                 gnt_found;
    logic [CIB-1:0]       gnt_id;

    logic [N_CLIENTS-1:0] rsp_valid;
    logic [N_CLIENTS-1:0] deliver;
    logic                 sb_deq;
    logic                 buf_empty_d;
    logic                 all_zero_d;
    logic                 drain_done;

    logic [CIB-1:0]       sb_tag;
    logic                 sb_tag_ok;

    assign sb_tag    = sb_firstMeta_i[N_META_BITS +: CIB];
    assign sb_tag_ok = (int'(sb_tag) < N_CLIENTS);

    // Eligibility: requesting, under cap, running, and room in the scoreboard.
    // Reset gates everything so grants are forced low while reset is held.
    always_comb begin
        for (int c = 0; c < N_CLIENTS; c++) begin
            elig[c] = reset_i && req_en_i[c] && (cnt_q[c] < CNT_W'(MAX_OUTSTANDING)) &&
                      (state_q == S_RUN) && sb_notFull_i;
        end
    end

    // Round-robin pick: first eligible client at or after rr_ptr_q.
    always_comb begin
        int sel;
        grant     = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        sel       = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            sel = (int'(rr_ptr_q) + i) % N_CLIENTS;
            if (!gnt_found && elig[sel]) begin
                gnt_found  = 1'b1;
                grant[sel] = 1'b1;
                gnt_id     = CIB'(sel);
            end
        end
        rr_ptr_d = gnt_found ? CIB'((int'(gnt_id) + 1) % N_CLIENTS) : rr_ptr_q;
    end

    assign req_grant_o  = grant;
    assign sb_enq_en_o  = gnt_found;
    assign sb_enqMeta_o = {gnt_id, req_meta_i[int'(gnt_id)*N_META_BITS +: N_META_BITS]};
    assign grant_idx_o  = sb_enqIdx_i;

`ifdef CCI_MPF_SCOREBOARD_ARB_OUT_REG_EN
    logic [N_DATA_BITS-1:0] sk_data_q [2];
    logic [MW-1:0]          sk_meta_q [2];
    logic                   sk_wr_q;
    logic                   sk_rd_q;
    logic [1:0]             sk_cnt_q;
    logic [1:0]             sk_cnt_d;
    logic                   sk_pop;
    logic [CIB-1:0]         sk_tag;
    logic                   sk_tag_ok;

    // Pull from the scoreboard whenever the skid buffer has a free slot; this
    // breaks the combinational rsp_ready -> sb_deq_en path.
    assign sb_deq    = reset_i && sb_notEmpty_i && (sk_cnt_q != 2'd2);
    assign sk_tag    = sk_meta_q[sk_rd_q][N_META_BITS +: CIB];
    assign sk_tag_ok = (int'(sk_tag) < N_CLIENTS);

    // Present the skid head to its owner; a handshake pops it.
    always_comb begin
        rsp_valid = '0;
        deliver   = '0;
        sk_pop    = 1'b0;
        if ((sk_cnt_q != 2'd0) && sk_tag_ok) begin
            rsp_valid[sk_tag] = 1'b1;
            sk_pop            = rsp_ready_i[sk_tag];
            deliver[sk_tag]   = sk_pop;
        end
    end

    assign sk_cnt_d    = sk_cnt_q + {1'b0, sb_deq} - {1'b0, sk_pop};
    assign buf_empty_d = (sk_cnt_d == 2'd0);
    assign rsp_data_o  = sk_data_q[sk_rd_q];
    assign rsp_meta_o  = sk_meta_q[sk_rd_q][N_META_BITS-1:0];

    // Skid buffer occupancy and pointers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sk_wr_q  <= 1'b0;
            sk_rd_q  <= 1'b0;
            sk_cnt_q <= 2'd0;
        end else begin
            if (sb_deq) sk_wr_q <= ~sk_wr_q;
            if (sk_pop) sk_rd_q <= ~sk_rd_q;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    // Capture the scoreboard head into the free skid slot.
    always_ff @(posedge clk_i) begin
        if (sb_deq) begin
            sk_data_q[sk_wr_q] <= sb_first_i;
            sk_meta_q[sk_wr_q] <= sb_firstMeta_i;
        end
    end
`else
    // Head of the scoreboard goes straight to its owner; a stalled owner
    // blocks everyone behind it, which keeps responses in allocation order.
    always_comb begin
        rsp_valid = '0;
        deliver   = '0;
        sb_deq    = 1'b0;
        if (reset_i && sb_notEmpty_i && sb_tag_ok) begin
            rsp_valid[sb_tag] = 1'b1;
            sb_deq            = rsp_ready_i[sb_tag];
            deliver[sb_tag]   = sb_deq;
        end
    end

    assign buf_empty_d = 1'b1;
    assign rsp_data_o  = sb_first_i;
    assign rsp_meta_o  = sb_firstMeta_i[N_META_BITS-1:0];
`endif

    assign rsp_valid_o = rsp_valid;
    assign sb_deq_en_o = sb_deq;

    // Next outstanding counts; a simultaneous grant and delivery cancel out.
    always_comb begin
        all_zero_d = 1'b1;
        for (int c = 0; c < N_CLIENTS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (grant[c] && !deliver[c]) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end else if (!grant[c] && deliver[c] && (cnt_q[c] != '0)) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
            if (cnt_d[c] != '0) all_zero_d = 1'b0;
        end
    end

    // Drain completes on the edge where the last outstanding entry leaves,
    // so drained_o rises in the cycle right after the final delivery.
    assign drain_done = all_zero_d && (!sb_notEmpty_i || sb_deq) && buf_empty_d;

    // Per-client outstanding counters.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int c = 0; c < N_CLIENTS; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < N_CLIENTS; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    // Arbitration pointer and drain FSM with registered drained flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_RUN;
            drained_q <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                S_RUN: begin
                    if (drain_req_i) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!drain_req_i) begin
                        state_q <= S_RUN;
                    end else if (drain_done) begin
                        state_q   <= S_IDLE;
                        drained_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!drain_req_i) begin
                        state_q   <= S_RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    assign drained_o = drained_q;

`ifndef SYNTHESIS
    // Protocol sanity checks; any violation stops simulation.
    always @(posedge clk_i) begin
        if (reset_i) begin
            assert ($onehot0(grant))
                else $fatal(1, "scoreboard_arb: req_grant not one-hot0 (%b)", grant);
            if (sb_notEmpty_i) begin
                assert (sb_tag_ok)
                    else $fatal(1, "scoreboard_arb: head tag %0d out of range", sb_tag);
            end
            for (int c = 0; c < N_CLIENTS; c++) begin
                if (deliver[c]) begin
                    assert (cnt_q[c] != '0)
                        else $fatal(1, "scoreboard_arb: delivery to client %0d with nothing outstanding", c);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_scoreboard_arb.sv
// Directed bench for cci_mpf_prim_scoreboard_arb (default build, combinational
// response path). A small ring-buffer scoreboard model stands in for the
// shared scoreboard: it records enqueued meta and presents entry index as data.

module tb_cci_mpf_prim_scoreboard_arb;

    localparam int NC = 4;
    localparam int NE = 32;
    localparam int ND = 64;
    localparam int NM = 1;
    localparam int MO = 8;
    localparam logic [63:0] DBASE = 64'hDA7A_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] req_en;
    logic [NC-1:0] req_meta;
    logic [NC-1:0] req_grant;
    logic [4:0]    grant_idx;
    logic          sb_enq_en;
    logic [2:0]    sb_enqMeta;
    logic          sb_notFull;
    logic [4:0]    sb_enqIdx;
    logic          sb_deq_en;
    logic          sb_notEmpty;
    logic [ND-1:0] sb_first;
    logic [2:0]    sb_firstMeta;
    logic [NC-1:0] rsp_valid;
    logic [NC-1:0] rsp_ready;
    logic [ND-1:0] rsp_data;
    logic [NM-1:0] rsp_meta;
    logic          drain_req;
    logic          drained;

    logic          sb_hold;
    logic          sb_full;

    logic [2:0]    mem [0:31];
    logic [4:0]    hd;
    logic [4:0]    tl;
    logic [5:0]    qn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cci_mpf_prim_scoreboard_arb #(
        .N_CLIENTS      (NC),
        .N_ENTRIES      (NE),
        .N_DATA_BITS    (ND),
        .N_META_BITS    (NM),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst_n),
        .req_en_i       (req_en),
        .req_meta_i     (req_meta),
        .req_grant_o    (req_grant),
        .grant_idx_o    (grant_idx),
        .sb_enq_en_o    (sb_enq_en),
        .sb_enqMeta_o   (sb_enqMeta),
        .sb_notFull_i   (sb_notFull),
        .sb_enqIdx_i    (sb_enqIdx),
        .sb_deq_en_o    (sb_deq_en),
        .sb_notEmpty_i  (sb_notEmpty),
        .sb_first_i     (sb_first),
        .sb_firstMeta_i (sb_firstMeta),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_meta_o     (rsp_meta),
        .drain_req_i    (drain_req),
        .drained_o      (drained)
    );

    // Scoreboard model: in-order ring buffer, cleared by the same reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd <= '0;
            tl <= '0;
            qn <= '0;
        end else begin
            if (sb_enq_en) begin
                mem[tl] <= sb_enqMeta;
                tl      <= tl + 5'd1;
            end
            if (sb_deq_en) hd <= hd + 5'd1;
            qn <= qn + {5'd0, sb_enq_en} - {5'd0, sb_deq_en};
        end
    end

    assign sb_notEmpty  = !sb_hold && (qn != 6'd0);
    assign sb_notFull   = !sb_full && (qn != 6'd32);
    assign sb_enqIdx    = tl;
    assign sb_first     = DBASE | {59'd0, hd};
    assign sb_firstMeta = mem[hd];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    initial begin
        logic [2:0] em [4];
        int         tags [10];
        logic [3:0] e;

        em   = '{3'b000, 3'b011, 3'b100, 3'b111};
        tags = '{0, 1, 2, 3, 0, 1, 2, 3, 2, 3};

        req_en    = '0;
        req_meta  = '0;
        rsp_ready = '0;
        drain_req = 1'b0;
        sb_hold   = 1'b1;
        sb_full   = 1'b0;

        // Reset held: outputs forced low even with requests pending.
        #2;
        req_en = 4'hF;
        #1;
        chk("rst_grant",   64'(req_grant), 64'd0);
        chk("rst_enq",     64'(sb_enq_en), 64'd0);
        chk("rst_deq",     64'(sb_deq_en), 64'd0);
        chk("rst_rsp",     64'(rsp_valid), 64'd0);
        chk("rst_drained", 64'(drained),   64'd0);
        req_en = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with everyone requesting, nothing delivered.
        req_meta = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_en = 4'hF;
            #1;
            e = 4'b0001 << (k % 4);
            chk("rr_grant", 64'(req_grant), 64'(e));
            chk("rr_tag",   64'(sb_enqMeta), 64'(em[k % 4]));
        end

        // Scoreboard full freezes grants and the pointer.
        @(negedge clk);
        req_en = 4'b0100;
        #1;
        chk("pre_full_grant", 64'(req_grant), 64'b0100);
        @(negedge clk);
        sb_full = 1'b1;
        req_en  = 4'hF;
        #1;
        chk("full_grant", 64'(req_grant), 64'd0);
        chk("full_enq",   64'(sb_enq_en), 64'd0);
        @(negedge clk);
        #1;
        chk("full_grant2", 64'(req_grant), 64'd0);
        @(negedge clk);
        sb_full = 1'b0;
        #1;
        chk("full_release", 64'(req_grant), 64'b1000);

        // Flush the 10 queued entries in order.
        @(negedge clk);
        req_en    = '0;
        sb_hold   = 1'b0;
        rsp_ready = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1;
            e = 4'b0001 << tags[k];
            chk("flush_valid", 64'(rsp_valid), 64'(e));
            chk("flush_data",  rsp_data, DBASE + 64'(k));
            chk("flush_meta",  64'(rsp_meta), 64'(tags[k] % 2));
            @(negedge clk);
        end
        #1;
        chk("flush_empty", 64'(rsp_valid), 64'd0);

        // Steering: entries tagged 2,0,2; clients 0 and 2 ready.
        @(negedge clk);
        sb_hold   = 1'b1;
        rsp_ready = '0;
        req_meta  = '0;
        req_en    = 4'b0100;
        #1;
        chk("st_grant0", 64'(req_grant), 64'b0100);
        chk("st_idx0",   64'(grant_idx), 64'd10);
        @(negedge clk);
        req_en = 4'b0001;
        #1;
        chk("st_grant1", 64'(req_grant), 64'b0001);
        chk("st_idx1",   64'(grant_idx), 64'd11);
        @(negedge clk);
        req_en = 4'b0100;
        #1;
        chk("st_grant2", 64'(req_grant), 64'b0100);
        chk("st_idx2",   64'(grant_idx), 64'd12);
        @(negedge clk);
        req_en    = '0;
        sb_hold   = 1'b0;
        rsp_ready = 4'b0101;
        #1;
        chk("st_valid0", 64'(rsp_valid), 64'b0100);
        chk("st_data0",  rsp_data, DBASE + 64'd10);
        chk("st_deq0",   64'(sb_deq_en), 64'd1);
        @(negedge clk);
        #1;
        chk("st_valid1", 64'(rsp_valid), 64'b0001);
        chk("st_data1",  rsp_data, DBASE + 64'd11);
        @(negedge clk);
        #1;
        chk("st_valid2", 64'(rsp_valid), 64'b0100);
        chk("st_data2",  rsp_data, DBASE + 64'd12);
        @(negedge clk);
        #1;
        chk("st_empty_valid", 64'(rsp_valid), 64'd0);
        chk("st_empty_deq",   64'(sb_deq_en), 64'd0);

        // Stalled head: client 2 not ready.
        req_en    = 4'b0100;
        rsp_ready = 4'b0001;
        #1;
        chk("stall_grant", 64'(req_grant), 64'b0100);
        @(negedge clk);
        req_en = '0;
        #1;
        chk("stall_valid", 64'(rsp_valid), 64'b0100);
        chk("stall_deq",   64'(sb_deq_en), 64'd0);
        @(negedge clk);
        #1;
        chk("stall_valid2", 64'(rsp_valid), 64'b0100);
        chk("stall_deq2",   64'(sb_deq_en), 64'd0);
        chk("stall_data",   rsp_data, DBASE + 64'd13);
        rsp_ready = 4'b0100;
        #1;
        chk("stall_release", 64'(sb_deq_en), 64'd1);
        @(negedge clk);
        #1;
        chk("stall_empty", 64'(rsp_valid), 64'd0);

        // Cap: client 1 alone, no deliveries -> 8 grants then none.
        sb_hold   = 1'b1;
        rsp_ready = '0;
        req_en    = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("cap_grant", 64'(req_grant), 64'b0010);
            @(negedge clk);
        end
        #1;
        chk("cap_block", 64'(req_grant), 64'd0);
        @(negedge clk);
        #1;
        chk("cap_block2", 64'(req_grant), 64'd0);
        sb_hold   = 1'b0;
        rsp_ready = 4'b0010;
        #1;
        chk("cap_deliver",       64'(sb_deq_en), 64'd1);
        chk("cap_deliver_valid", 64'(rsp_valid), 64'b0010);
        chk("cap_deliver_grant", 64'(req_grant), 64'd0);
        @(negedge clk);
        sb_hold = 1'b1;
        #1;
        chk("cap_regrant", 64'(req_grant), 64'b0010);
        @(negedge clk);
        #1;
        chk("cap_reblock", 64'(req_grant), 64'd0);

        // Deliver three more so five remain outstanding.
        req_en  = '0;
        sb_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        sb_hold = 1'b1;

        // Drain with five outstanding entries for client 1.
        drain_req = 1'b1;
        @(negedge clk);
        req_en = 4'hF;
        #1;
        chk("drain_nogrant", 64'(req_grant), 64'd0);
        chk("drain_busy",    64'(drained),   64'd0);
        sb_hold   = 1'b0;
        rsp_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("drain_grant", 64'(req_grant), 64'd0);
            chk("drain_valid", 64'(rsp_valid), 64'b0010);
            chk("drain_data",  rsp_data, DBASE + 64'(18 + k));
            chk("drain_flag",  64'(drained),   64'd0);
            @(negedge clk);
        end
        #1;
        chk("drained_set",  64'(drained),   64'd1);
        chk("idle_nogrant", 64'(req_grant), 64'd0);
        drain_req = 1'b0;
        #1;
        chk("idle_hold_flag",  64'(drained),   64'd1);
        chk("idle_hold_grant", 64'(req_grant), 64'd0);
        @(negedge clk);
        #1;
        chk("resume_flag",  64'(drained),   64'd0);
        chk("resume_grant", 64'(req_grant), 64'b0100);

        // Async reset in the middle of traffic.
        @(negedge clk);
        #1;
        chk("pre_rst_valid", 64'(rsp_valid), 64'b0100);
        chk("pre_rst_grant", 64'(req_grant), 64'b1000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(req_grant), 64'd0);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_enq",   64'(sb_enq_en), 64'd0);
        chk("mid_rst_deq",   64'(sb_deq_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant",   64'(req_grant), 64'b0001);
        chk("post_rst_valid",   64'(rsp_valid), 64'd0);
        chk("post_rst_drained", 64'(drained),   64'd0);
        @(negedge clk);
        req_en = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cci_mpf_prim_scoreboard_arb.md
Name: cci_mpf_prim_scoreboard_arb

Overview:
Shares one ordered scoreboard (output-buffered variant) among N_CLIENTS requesters. Round-robin arbitrates entry allocation and tags each entry's meta-data with the owning client ID. Steers in-order scoreboard output to the owning client and enforces a per-client outstanding-entry cap. Provides a drain handshake so software or a parent controller can quiesce the scoreboard.

Parameters:
N_CLIENTS, 4, number of requesters (2..16)
N_ENTRIES, 32, scoreboard depth; sets index width
N_DATA_BITS, 64, response payload width
N_META_BITS, 1, client meta-data width, excluding the client tag
MAX_OUTSTANDING, 8, per-client cap on allocated, undelivered entries (1..N_ENTRIES)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_en  in  N_CLIENTS  per-client allocation request
req_meta  in  N_CLIENTS*N_META_BITS  per-client meta; client c occupies slice [c*N_META_BITS +: N_META_BITS]
req_grant  out  N_CLIENTS  one-hot grant, combinational, same cycle as the request
grant_idx  out  $clog2(N_ENTRIES)  scoreboard index of the granted entry (= sb_enqIdx)
sb_enq_en  out  1  scoreboard allocate
sb_enqMeta  out  N_META_BITS+CIB  {client tag, meta}; CIB = max(1,$clog2(N_CLIENTS))
sb_notFull  in  1  scoreboard not full
sb_enqIdx  in  $clog2(N_ENTRIES)  scoreboard allocated index
sb_deq_en  out  1  scoreboard dequeue
sb_notEmpty  in  1  scoreboard head valid
sb_first  in  N_DATA_BITS  scoreboard head data
sb_firstMeta  in  N_META_BITS+CIB  scoreboard head meta
rsp_valid  out  N_CLIENTS  response valid; at most one bit set
rsp_ready  in  N_CLIENTS  per-client response accept
rsp_data  out  N_DATA_BITS  shared response data
rsp_meta  out  N_META_BITS  shared response meta, tag stripped
drain_req  in  1  level request to quiesce
drained  out  1  drain complete

Behaviour:
- Reset (reset==0, async): rr_ptr=0; cnt[*]=0; state=RUN; drained=0. All outputs req_grant, sb_enq_en, sb_deq_en, rsp_valid driven 0 while in reset.
- Eligibility: elig[c] = req_en[c] && cnt[c] < MAX_OUTSTANDING && state==RUN && sb_notFull.
- Arbitration: grant the first eligible client at or after rr_ptr (mod N_CLIENTS). On grant to client c, rr_ptr <= (c+1) mod N_CLIENTS. With no grant, rr_ptr holds. At most one grant per cycle.
- Enqueue: sb_enq_en = |req_grant. sb_enqMeta = {c, req_meta slice c}. grant_idx = sb_enqIdx.
- Delivery, base path: head client h = sb_firstMeta tag. rsp_valid[h] = sb_notEmpty. sb_deq_en = sb_notEmpty && rsp_ready[h]. rsp_data = sb_first; rsp_meta = low N_META_BITS of sb_firstMeta. A stalled head blocks all clients; this in-order behaviour is intended.
- Counters:
  - cnt[c] increments on grant to c.
  - cnt[c] decrements on delivery to c.
  - Grant and delivery to c in the same cycle leave cnt[c] unchanged.
  - Counter width $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING.
- FSM:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN: no grants. Deliveries continue. -> IDLE when all cnt==0 and sb_notEmpty==0.
  - IDLE: drained=1, no grants. -> RUN when drain_req=0; drained cleared on the same edge.
  - drain_req dropped while in DRAIN -> back to RUN.
- Boundaries:
  - sb_notFull=0 blocks all grants; rr_ptr is unchanged.
  - A client at the cap is skipped and the next eligible client is granted.
  - N_CLIENTS=1 degenerates to pass-through with a 1-bit tag of 0.
- Sim-only assertions, fatal:
  - delivery to a client with cnt==0
  - tag value >= N_CLIENTS
  - req_grant not one-hot0

Optional Feature:
- Macro: CCI_MPF_SCOREBOARD_ARB_OUT_REG_EN.
- When defined: a 2-entry skid buffer sits between the scoreboard head and the rsp_* outputs, so rsp_* are registered.
  - Delivery latency is +1 cycle.
  - Full throughput of 1 response per cycle is sustained.
  - sb_deq_en = sb_notEmpty && skid buffer has space; it no longer depends combinationally on rsp_ready.
  - Counters decrement on the rsp handshake, not on sb_deq_en.
  - DRAIN also requires the skid buffer to be empty.
- When undefined: combinational path as described in Behaviour.

Test Plan:
- Round-robin: N_CLIENTS=4, req_en=4'b1111 held for 8 cycles, sb_notFull=1 -> grants to clients 0,1,2,3,0,1,2,3; sb_enqMeta tags match the granted client.
- Cap: client 1 alone requests with MAX_OUTSTANDING=8 and no deliveries -> exactly 8 grants, then req_grant=0; one delivery to client 1 -> one more grant.
- Steering: entries tagged 2,0,2 at the head, rsp_ready=4'b0101 -> rsp_valid one-hot 4'b0100, 4'b0001, 4'b0100 on successive cycles, with data in order; holding rsp_ready[2]=0 stalls the head and sb_deq_en=0.
- Full: sb_notFull=0 with all clients requesting -> no grants, rr_ptr unchanged; on release, the next grant goes to the client at rr_ptr.
- Drain: 5 entries outstanding, drain_req=1 -> no new grants; drained=1 one cycle after the last delivery; drain_req=0 -> drained=0 and granting resumes.
- Async reset mid-traffic: reset=0 between clock edges -> cnt=0, rsp_valid=0, req_grant=0 immediately; state RUN after release.
